// File: rtl/kyber_compress_unit.sv
// Kyber coefficient compress/decompress unit.
// A 3-stage pipeline processes LANES 12-bit coefficients per beat. Each beat
// carries its own mode and d, so consecutive beats can mix operations freely.
// The whole pipeline advances together whenever the output slot is empty or
// is being accepted. A single global enable keeps the beats in order.
module kyber_compress_unit #(
  parameter int LANES  = 4,
  parameter int Q      = 3329,
  parameter int N_COEF = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [3:0]            in_d,
  input  logic [12*LANES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [12*LANES-1:0]   out_data,
  output logic                  out_last,
  output logic                  out_err
);

  localparam int BEATS = N_COEF / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Wide enough for 2^11 * 4095 + Q/2 and for Q * 2047 + 2^10 without truncation.
  localparam int PW    = 26;
  localparam int DW    = 12 * LANES;

  localparam logic [PW-1:0] Q_W       = PW'(Q);
  localparam logic [PW-1:0] HALF_Q    = PW'(Q / 2);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  // Only these d values are legal; any other d zeroes the beat and flags an error.
  function automatic logic d_is_legal(input logic [3:0] d);
    case (d)
      4'd1, 4'd4, 4'd5, 4'd10, 4'd11: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Stage-2 lane work: the compress quotient, or the unshifted decompress sum.
  function automatic logic [PW-1:0] lane_s2(input logic mode, input logic [3:0] d,
                                            input logic [11:0] x);
    logic [PW-1:0] xw;
    logic [PW-1:0] mask;
    xw   = PW'(x);
    mask = (PW'(1) << d) - PW'(1);
    if (!mode) return ((xw << d) + HALF_Q) / Q_W;
    else       return (xw & mask) * Q_W + (PW'(1) << (d - 4'd1));
  endfunction

  // Stage-3 lane work: reduce the quotient mod 2^d, or round by shifting.
  function automatic logic [11:0] lane_s3(input logic mode, input logic [3:0] d,
                                          input logic [PW-1:0] v);
    if (!mode) return 12'(v & ((PW'(1) << d) - PW'(1)));
    else       return 12'(v >> d);
  endfunction

  logic                  adv;
  logic                  s1_valid;
  logic                  s1_mode;
  logic [3:0]            s1_d;
  logic [DW-1:0]         s1_data;
  logic                  s2_valid;
  logic                  s2_mode;
  logic [3:0]            s2_d;
  logic                  s2_legal;
  logic                  s2_err;
  logic [PW*LANES-1:0]   s2_val;
  logic [PW*LANES-1:0]   s2_val_n;
  logic                  s2_err_n;
  logic                  s3_valid;
  logic [DW-1:0]         s3_data;
  logic                  s3_err;
  logic [DW-1:0]         s3_data_n;
  logic [CW-1:0]         beat_cnt;

  // Outputs are forced quiet while reset is held, even before the first reset edge.
  assign out_valid = s3_valid & ~rst;
  assign out_data  = rst ? '0 : s3_data;
  assign out_err   = s3_err & ~rst;
  assign out_last  = out_valid & (beat_cnt == LAST_BEAT);
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = ~rst & adv;

  // Stage 1: capture the accepted beat together with its mode and d.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_d     <= 4'd0;
      s1_data  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_mode  <= in_mode;
      s1_d     <= in_d;
      s1_data  <= in_data;
    end
  end

  // Stage 2 combinational: per-lane product or quotient, plus error detection.
  always_comb begin
    s2_val_n = '0;
    s2_err_n = ~d_is_legal(s1_d);
    for (int i = 0; i < LANES; i++) begin
      s2_val_n[PW*i +: PW] = lane_s2(s1_mode, s1_d, s1_data[12*i +: 12]);
      if (!s1_mode && (PW'(s1_data[12*i +: 12]) >= Q_W)) s2_err_n = 1'b1;
    end
  end

  // Stage 2 register: intermediate lane values and the beat's error status.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_mode  <= 1'b0;
      s2_d     <= 4'd0;
      s2_legal <= 1'b0;
      s2_err   <= 1'b0;
      s2_val   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_mode  <= s1_mode;
      s2_d     <= s1_d;
      s2_legal <= d_is_legal(s1_d);
      s2_err   <= s2_err_n;
      s2_val   <= s2_val_n;
    end
  end

  // Stage 3 combinational: final reduce/round; an illegal d zeroes every lane.
  always_comb begin
    s3_data_n = '0;
    if (s2_legal) begin
      for (int i = 0; i < LANES; i++) begin
        s3_data_n[12*i +: 12] = lane_s3(s2_mode, s2_d, s2_val[PW*i +: PW]);
      end
    end
  end

  // Stage 3 register: the output slot, held unchanged while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_data  <= '0;
      s3_err   <= 1'b0;
    end else if (adv) begin
      s3_valid <= s2_valid;
      s3_data  <= s3_data_n;
      s3_err   <= s2_valid & s2_err;
    end
  end

  // Beat counter: advances on each output transfer and wraps after the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (beat_cnt == LAST_BEAT) beat_cnt <= '0;
      else                       beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_kyber_compress_unit.sv
// Self-checking bench for kyber_compress_unit.
// Expected beats come from a behavioural model. Each is queued when the DUT
// accepts an input beat, and is compared when the matching output beat transfers.
module tb_kyber_compress_unit;

  localparam int LANES  = 4;
  localparam int Q      = 3329;
  localparam int N_COEF = 256;
  localparam int BEATS  = N_COEF / LANES;
  localparam int DW     = 12 * LANES;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } beat_exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [3:0]    in_d;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_err;

  beat_exp_t sb[$];
  int        checks     = 0;
  int        errors     = 0;
  int        out_count  = 0;
  int        last_seen  = 0;
  logic      last_in_fire = 1'b0;
  int        legal_list[5] = '{1, 4, 5, 10, 11};

  kyber_compress_unit #(.LANES(LANES), .Q(Q), .N_COEF(N_COEF)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_d      (in_d),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic legal_d(input int d);
    return (d == 1) || (d == 4) || (d == 5) || (d == 10) || (d == 11);
  endfunction

  function automatic logic [11:0] model_compress(input int x, input int d);
    longint num;
    num = (longint'(x) << d) + longint'(Q / 2);
    return 12'((num / Q) % (longint'(1) << d));
  endfunction

  function automatic logic [11:0] model_decompress(input int y, input int d);
    longint yy;
    yy = longint'(y) % (longint'(1) << d);
    return 12'((longint'(Q) * yy + (longint'(1) << (d - 1))) >> d);
  endfunction

  function automatic beat_exp_t model_beat(input logic mode, input logic [3:0] d,
                                           input logic [DW-1:0] data);
    beat_exp_t e;
    int di;
    int x;
    di     = int'(d);
    e.data = '0;
    e.err  = 1'b0;
    if (!legal_d(di)) begin
      e.err = 1'b1;
      return e;
    end
    for (int i = 0; i < LANES; i++) begin
      x = int'(data[12*i +: 12]);
      if (!mode) begin
        e.data[12*i +: 12] = model_compress(x, di);
        if (x >= Q) e.err = 1'b1;
      end else begin
        e.data[12*i +: 12] = model_decompress(x, di);
      end
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] lanes4(input int a, input int b, input int c, input int e);
    return {12'(e), 12'(c), 12'(b), 12'(a)};
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return DW'({$urandom(), $urandom()});
  endfunction

  function automatic int noisy(input int v, input int d);
    return (v + (int'($urandom % 8) << d)) & 4095;
  endfunction

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare a transferring output beat against the front of the scoreboard.
  task automatic checkOutput();
    beat_exp_t e;
    logic      exp_last;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("[TB] FAIL unexpected_beat observed=%0h expected=none", out_data);
      return;
    end
    e        = sb.pop_front();
    exp_last = ((out_count % BEATS) == BEATS - 1);
    check_value("out_data", out_data, e.data);
    check_value("out_err", out_err, e.err);
    check_value("out_last", out_last, exp_last);
    out_count++;
    if (out_last) last_seen++;
  endtask

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic run_cycle();
    @(negedge clk);
    if (rst) begin
      sb.delete();
      out_count    = 0;
      last_in_fire = 1'b0;
    end else begin
      last_in_fire = in_valid && in_ready;
      if (out_valid && out_ready) checkOutput();
      if (last_in_fire) sb.push_back(model_beat(in_mode, in_d, in_data));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic m, input logic [3:0] d,
                               input logic [DW-1:0] data, input logic ordy);
    in_valid  = v;
    in_mode   = m;
    in_d      = d;
    in_data   = data;
    out_ready = ordy;
    run_cycle();
  endtask

  initial begin
    int            sent;
    int            budget;
    logic          m;
    logic [3:0]    d;
    logic [DW-1:0] data;
    logic          v;
    int            dd;

    // Reset state
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_d = 4'd0; in_data = '0; out_ready = 1'b1;
    run_cycle();
    run_cycle();
    check_value("rst_out_valid", out_valid, 0);
    check_value("rst_in_ready", in_ready, 0);
    check_value("rst_out_data", out_data, 0);
    check_value("rst_out_last", out_last, 0);
    check_value("rst_out_err", out_err, 0);
    rst = 1'b0;
    #1;
    check_value("post_rst_in_ready", in_ready, 1);

    // Compress d=4 with three-cycle latency and known lane results
    applyStimulus(1, 0, 4, lanes4(0, 1665, 3328, 1), 1);
    check_value("lat_c1", out_valid, 0);
    applyStimulus(0, 0, 0, '0, 1);
    check_value("lat_c2", out_valid, 0);
    applyStimulus(0, 0, 0, '0, 1);
    check_value("lat_c3", out_valid, 1);
    check_value("cmp_d4_data", out_data, lanes4(0, 8, 0, 0));
    check_value("cmp_d4_err", out_err, 0);
    applyStimulus(0, 0, 0, '0, 1);

    // Back-to-back decompress beats with different d
    applyStimulus(1, 1, 4, lanes4(8, 0, 0, 0), 1);
    applyStimulus(1, 1, 1, lanes4(1, 0, 0, 0), 1);
    applyStimulus(1, 1, 11, lanes4(2047, 0, 0, 0), 1);
    check_value("dec_b1_lane0", out_data[11:0], 12'd1665);
    applyStimulus(0, 0, 0, '0, 1);
    check_value("dec_b2_valid", out_valid, 1);
    check_value("dec_b2_lane0", out_data[11:0], 12'd1665);
    applyStimulus(0, 0, 0, '0, 1);
    check_value("dec_b3_valid", out_valid, 1);
    check_value("dec_b3_lane0", out_data[11:0], 12'd3327);
    applyStimulus(0, 0, 0, '0, 1);

    // Out-of-range compress input and an illegal d
    applyStimulus(1, 0, 4, lanes4(3329, 3329, 3329, 3329), 1);
    applyStimulus(1, 0, 7, rand_data() | lanes4(5, 0, 0, 0), 1);
    applyStimulus(0, 0, 0, '0, 1);
    check_value("oor_data", out_data, 0);
    check_value("oor_err", out_err, 1);
    applyStimulus(0, 0, 0, '0, 1);
    check_value("bad_d_data", out_data, 0);
    check_value("bad_d_err", out_err, 1);
    applyStimulus(0, 0, 0, '0, 1);

    // Stall with three beats in flight, then drain
    applyStimulus(1, 0, 5, rand_data(), 0);
    applyStimulus(1, 1, 10, rand_data(), 0);
    applyStimulus(1, 0, 11, rand_data(), 0);
    check_value("stall_out_valid", out_valid, 1);
    check_value("stall_in_ready", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 10, rand_data(), 0);
      check_value("stall_hold_ready", in_ready, 0);
      check_value("stall_hold_valid", out_valid, 1);
      check_value("stall_hold_data", out_data, sb[0].data);
      check_value("stall_hold_err", out_err, sb[0].err);
    end
    applyStimulus(0, 0, 0, '0, 1);
    check_value("drain_1", out_valid, 1);
    applyStimulus(0, 0, 0, '0, 1);
    check_value("drain_2", out_valid, 1);
    applyStimulus(0, 0, 0, '0, 1);
    check_value("drain_3", out_valid, 0);
    check_value("drain_sb", sb.size(), 0);

    // Reset with three beats in flight
    applyStimulus(1, 0, 10, rand_data(), 1);
    applyStimulus(1, 1, 5, rand_data(), 1);
    applyStimulus(1, 0, 1, rand_data(), 1);
    check_value("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    applyStimulus(0, 0, 0, '0, 1);
    check_value("mid_rst_valid", out_valid, 0);
    check_value("mid_rst_ready", in_ready, 0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, '0, 1);
      check_value("post_rst_quiet", out_valid, 0);
    end

    // Random stream of 70 beats with random backpressure
    last_seen = 0;
    sent      = 0;
    budget    = 0;
    m    = 1'($urandom % 2);
    d    = 4'(legal_list[$urandom % 5]);
    data = rand_data();
    while (sent < 70 && budget < 3000) begin
      v = (($urandom % 4) != 0);
      applyStimulus(v, m, d, data, ($urandom % 2) == 1);
      budget++;
      if (last_in_fire) begin
        sent++;
        m    = 1'($urandom % 2);
        d    = 4'(legal_list[$urandom % 5]);
        data = rand_data();
      end
    end
    check_value("stream_sent", sent, 70);
    budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      applyStimulus(0, 0, 0, '0, 1);
      budget++;
    end
    check_value("stream_drained", sb.size(), 0);
    check_value("stream_out_count", out_count, 70);
    check_value("stream_last_count", last_seen, 1);

    // Exhaustive sweep of every legal d in both modes
    for (int j = 0; j < 5; j++) begin
      dd = legal_list[j];
      for (int x = 0; x < 4096; x += 4) begin
        applyStimulus(1, 0, 4'(dd), lanes4(x, x + 1, x + 2, x + 3), 1);
      end
      for (int y = 0; y < (1 << dd); y += 4) begin
        applyStimulus(1, 1, 4'(dd),
                      lanes4(noisy(y, dd), noisy(y + 1, dd), noisy(y + 2, dd), noisy(y + 3, dd)), 1);
      end
    end
    budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      applyStimulus(0, 0, 0, '0, 1);
      budget++;
    end
    check_value("final_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kyber_compress_unit.md
KYBER_COMPRESS_UNIT -- requirements
Module: kyber_compress_unit

Parameters
REQ-001 SHALL provide parameter LANES, default 4, meaning coefficients processed per beat (1..8).
REQ-002 SHALL provide parameter Q, default 3329, meaning the Kyber modulus.
REQ-003 SHALL provide parameter N_COEF, default 256, meaning coefficients per polynomial; N_COEF/LANES SHALL be an integer.

Interface
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  input beat valid.
REQ-007 in_ready  out  1  unit accepts a beat this cycle.
REQ-008 in_mode  in  1  0 = compress, 1 = decompress; sampled with the beat.
REQ-009 in_d  in  4  bit-width d; sampled with the beat.
REQ-010 in_data  in  12*LANES  lane i occupies bits [12i+11:12i].
REQ-011 out_valid  out  1  output beat valid.
REQ-012 out_ready  in  1  downstream accepts the output beat.
REQ-013 out_data  out  12*LANES  per-lane result, right-aligned, zero-extended to 12 bits.
REQ-014 out_last  out  1  marks the final beat of a polynomial.
REQ-015 out_err  out  1  beat carried an illegal d or an out-of-range compress input.

Function
REQ-016 Transfer on either side SHALL occur only when valid and ready are both high in the same cycle.
REQ-017 Compress lane result SHALL be floor((2^d*x + floor(Q/2))/Q) mod 2^d, with x the 12-bit lane value.
REQ-018 Decompress lane result SHALL be floor((Q*y + 2^(d-1))/2^d), with y = lane value mod 2^d; upper lane bits SHALL be ignored.
REQ-019 Legal d SHALL be {1,4,5,10,11}; any other d SHALL force all lanes of that beat to 0 and set out_err.
REQ-020 In compress mode, any lane with x >= Q SHALL set out_err for the beat; the result SHALL still follow REQ-017.
REQ-021 Arithmetic SHALL be exact for all x in 0..4095 and all legal d; intermediate widths SHALL not truncate.
REQ-022 Datapath SHALL be a 3-stage pipeline: S1 register inputs, S2 product or quotient, S3 reduce or round and register the output; latency from accepted input to out_valid SHALL be 3 cycles without backpressure.
REQ-023 Mode and d SHALL travel with each beat; consecutive beats MAY differ in mode and d with no bubble.
REQ-024 Full throughput SHALL be one beat per cycle while out_ready is high.
REQ-025 The pipeline SHALL stall as a whole when out_valid=1 and out_ready=0; in_ready = out_ready OR NOT(out_valid), so a bubble anywhere advances.
REQ-026 A stalled output beat SHALL hold out_data, out_last and out_err stable until it is accepted.
REQ-027 A beat counter, width clog2(N_COEF/LANES), SHALL increment on each output transfer; out_last SHALL be 1 when the counter equals N_COEF/LANES-1, and the counter SHALL then wrap to 0.
REQ-028 A simultaneous input accept and output transfer SHALL both take effect in the same cycle with no beat lost or duplicated.

Reset
REQ-029 While rst=1: out_valid=0, out_data=0, out_last=0, out_err=0, all stage-valid flags=0, beat counter=0; in_ready SHALL be 0 during reset.
REQ-030 rst asserted mid-operation SHALL discard all in-flight beats; first in_ready=1 SHALL be the cycle after rst deasserts.

Verification
REQ-031 Compress d=4, lanes x={0,1665,3328,1}, out_ready=1 -> 3 cycles later out_data lanes {0,8,0,0}, out_err=0.
REQ-032 Decompress lanes {d=4,y=8},{d=1,y=1},{d=11,y=2047} on back-to-back beats -> lane0 results 1665, 1665, 3327 on consecutive cycles.
REQ-033 Compress d=4 x=3329 -> result 0, out_err=1; d=7 any data -> all lanes 0, out_err=1.
REQ-034 Stream 64 beats (LANES=4), with out_ready toggling randomly -> no loss or duplication, ordering preserved, out_last high only on beat 64, counter wraps for beat 65.
REQ-035 Hold out_ready=0 with 3 beats in flight -> in_ready=0, output frozen; release -> 3 beats drain on consecutive cycles.
REQ-036 Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 next cycle, no stale beat emitted, counter=0.
REQ-037 Exhaustive check: all x in 0..4095 against REQ-017, and all y in 0..2^d-1 against REQ-018, for every legal d, both modes.
